// File: rtl/dbg_ovl_pkg.sv
// Shared constants, state enum and slot-layout helper for the debug overlay line formatter.
// Optional frame counter is controlled by DBG_FRAME_CNT_EN in dbg_line_fmt.
package dbg_ovl_pkg;

  localparam int CODE_W        = 5;
  localparam int SLOTS         = 32;
  localparam int LINE_W        = SLOTS * CODE_W;
  localparam int NIBBLES       = 12;
  localparam int NIB_CNT_FIRST = 8;

  localparam logic [3:0]        LAST_NIB  = 4'(NIBBLES - 1);
  localparam logic [CODE_W-1:0] HEX_BASE  = 5'h00;
  localparam logic [CODE_W-1:0] SPACE     = 5'h10;
  localparam logic [LINE_W-1:0] ALL_SPACE = {SLOTS{SPACE}};

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    PUBLISH
  } fsm_state_t;

  // Nibble k (0 = addr MSB) lands in its slot; the gaps between fields stay SPACE.
  function automatic logic [4:0] nib_slot(input logic [3:0] k);
    logic [4:0] k5;
    k5 = {1'b0, k};
    if (k < 4'd4)      return 5'd31 - k5;
    else if (k < 4'd6) return 5'd30 - k5;
    else if (k < 4'd8) return 5'd29 - k5;
    else               return 5'd28 - k5;
  endfunction

endpackage

// File: rtl/dbg_hex_char.sv
// Maps one nibble to its overlay character code (hex digits occupy codes 0x00-0x0F).
module dbg_hex_char
  import dbg_ovl_pkg::*;
(
  input  logic [3:0]        nib,
  output logic [CODE_W-1:0] code
);

  assign code = HEX_BASE + {1'b0, nib};

endmodule

// File: rtl/dbg_line_fmt.sv
// Debug overlay line formatter: snapshots addr/data/flags on a vsync rise and renders them as a 32-slot line.
// Define DBG_FRAME_CNT_EN to add the 16-bit frame counter shown in slots 20-17.
//
// state   | meaning
// IDLE    | waiting for a capture edge
// CONV    | one nibble per cycle into the shadow line
// PUBLISH | shadow copied to dline, upd pulsed
module dbg_line_fmt
  import dbg_ovl_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              ena,
  input  logic              vsync,
  input  logic [15:0]       cpu_addr,
  input  logic [7:0]        cpu_data,
  input  logic [7:0]        flags,
  output logic [LINE_W-1:0] dline,
  output logic              upd,
  output logic              busy
);

`ifdef DBG_FRAME_CNT_EN
  localparam int SNAP_W = 48;
`else
  localparam int SNAP_W = 32;
`endif

  logic              vsync_q;
  logic              cap_edge;
  fsm_state_t        state;
  logic [LINE_W-1:0] shadow;
  logic [3:0]        nib_left;
  logic [3:0]        nib_k;
  logic [SNAP_W-1:0] snap;
  logic [3:0]        cur_nib;
  logic [CODE_W-1:0] hex_code;
  logic [CODE_W-1:0] cur_code;
  logic [4:0]        cur_slot;

  assign cap_edge = vsync & ~vsync_q & ena;
  assign nib_k    = LAST_NIB - nib_left;
  assign cur_slot = nib_slot(nib_k);

  // The snapshot is shifted left each CONV cycle so the current nibble is always on top.
  assign cur_nib  = snap[SNAP_W-1 -: 4];

  dbg_hex_char u_hex (
    .nib  (cur_nib),
    .code (hex_code)
  );

`ifdef DBG_FRAME_CNT_EN
  logic [15:0] frame_cnt;

  assign cur_code = hex_code;

  // Counts every capture edge, including ones ignored while a conversion runs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_cnt <= '0;
    end else if (cap_edge) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end
`else
  // Counter slots still consume their four CONV cycles so latency matches the full build.
  assign cur_code = (nib_k >= 4'(NIB_CNT_FIRST)) ? SPACE : hex_code;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vsync_q  <= 1'b0;
      state    <= IDLE;
      shadow   <= ALL_SPACE;
      dline    <= ALL_SPACE;
      upd      <= 1'b0;
      busy     <= 1'b0;
      nib_left <= '0;
      snap     <= '0;
    end else begin
      vsync_q <= vsync;
      upd     <= 1'b0;
      case (state)
        IDLE: begin
          if (cap_edge) begin
`ifdef DBG_FRAME_CNT_EN
            snap <= {cpu_addr, cpu_data, flags, frame_cnt};
`else
            snap <= {cpu_addr, cpu_data, flags};
`endif
            nib_left <= LAST_NIB;
            busy     <= 1'b1;
            state    <= CONV;
          end
        end
        CONV: begin
          shadow[int'(cur_slot)*CODE_W +: CODE_W] <= cur_code;
          snap <= snap << 4;
          if (nib_left == 4'd0) begin
            state <= PUBLISH;
          end else begin
            nib_left <= nib_left - 4'd1;
          end
        end
        PUBLISH: begin
          dline <= shadow;
          upd   <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dbg_line_fmt.sv
// Scoreboard bench for dbg_line_fmt: stimulus pushes expected lines, a negedge monitor checks each upd.
// Expectations for slots 20-17 follow DBG_FRAME_CNT_EN.
module tb_dbg_line_fmt;

  logic         clk;
  logic         reset;
  logic         ena;
  logic         vsync;
  logic [15:0]  cpu_addr;
  logic [7:0]   cpu_data;
  logic [7:0]   flags;
  logic [159:0] dline;
  logic         upd;
  logic         busy;

  typedef struct {
    logic [159:0] line;
    int           cyc;
  } exp_t;

  exp_t         sb[$];
  int           total = 0;
  int           bad = 0;
  int           cyc = 0;
  bit           ignore_upd = 0;
  logic         upd_prev = 0;
  logic [159:0] all_sp;
  logic [159:0] saved;

  dbg_line_fmt dut (
    .clk      (clk),
    .reset    (reset),
    .ena      (ena),
    .vsync    (vsync),
    .cpu_addr (cpu_addr),
    .cpu_data (cpu_data),
    .flags    (flags),
    .dline    (dline),
    .upd      (upd),
    .busy     (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [159:0] make_line(input logic [15:0] a, input logic [7:0] d,
                                             input logic [7:0] f, input logic [15:0] fc);
    logic [4:0]   s [32];
    logic [159:0] l;
    bit           fc_en;
`ifdef DBG_FRAME_CNT_EN
    fc_en = 1'b1;
`else
    fc_en = 1'b0;
`endif
    for (int i = 0; i < 32; i++) s[i] = 5'h10;
    s[31] = {1'b0, a[15:12]};
    s[30] = {1'b0, a[11:8]};
    s[29] = {1'b0, a[7:4]};
    s[28] = {1'b0, a[3:0]};
    s[26] = {1'b0, d[7:4]};
    s[25] = {1'b0, d[3:0]};
    s[23] = {1'b0, f[7:4]};
    s[22] = {1'b0, f[3:0]};
    if (fc_en) begin
      s[20] = {1'b0, fc[15:12]};
      s[19] = {1'b0, fc[11:8]};
      s[18] = {1'b0, fc[7:4]};
      s[17] = {1'b0, fc[3:0]};
    end
    for (int i = 0; i < 32; i++) l[i*5 +: 5] = s[i];
    return l;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!reset && upd) begin
      if (upd_prev) begin
        total++; bad++;
        $display("FAIL upd_width: upd high two cycles in a row at cycle %0d, required one-cycle pulse", cyc);
      end
      if (!ignore_upd) begin
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL upd_unexpected: upd at cycle %0d with dline=%h, required no update", cyc, dline);
        end else begin
          e = sb.pop_front();
          total++;
          if (dline !== e.line) begin
            bad++;
            $display("FAIL line_value: got %h required %h", dline, e.line);
          end
          total++;
          if (cyc !== e.cyc) begin
            bad++;
            $display("FAIL line_latency: upd at cycle %0d required cycle %0d", cyc, e.cyc);
          end
        end
      end
    end
    upd_prev = upd;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic check(input string name, input logic [159:0] got, input logic [159:0] req);
    total++;
    if (got !== req) begin
      bad++;
      $display("FAIL %s: got %h required %h", name, got, req);
    end
  endtask

  // Drives one capture edge (T0); returns 1 time unit after T0 with the inputs scrambled.
  task automatic capture(input logic [15:0] a, input logic [7:0] d, input logic [7:0] f,
                         input logic [15:0] fc, input bit expect_it);
    exp_t e;
    cpu_addr = a; cpu_data = d; flags = f; ena = 1'b1; vsync = 1'b1;
    tick();
    if (expect_it) begin
      e.line = make_line(a, d, f, fc);
      e.cyc  = cyc + 13;
      sb.push_back(e);
    end
    vsync = 1'b0; cpu_addr = ~a; cpu_data = ~d; flags = ~f;
  endtask

  task automatic wait_done(input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      tick();
      if (!busy && !upd && sb.size() == 0) done = 1'b1;
    end
    total++;
    if (!done) begin
      bad++;
      $display("FAIL %s_timeout: busy=%0b pending=%0d, required idle with nothing pending", name, busy, sb.size());
    end
    tick();
  endtask

  initial begin
    all_sp   = {32{5'h10}};
    reset    = 1'b1;
    ena      = 1'b0;
    vsync    = 1'b0;
    cpu_addr = '0;
    cpu_data = '0;
    flags    = '0;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    check("reset_dline", dline, all_sp);
    check("reset_upd", {159'b0, upd}, 160'd0);
    check("reset_busy", {159'b0, busy}, 160'd0);

    // Main capture; a second rise at T0+5 must be ignored but still counted.
    capture(16'hC0DE, 8'h5A, 8'h81, 16'h0000, 1'b1);
    check("busy_in_conv", {159'b0, busy}, 160'd1);
    repeat (4) tick();
    cpu_addr = 16'h1111; cpu_data = 8'h22; flags = 8'h33; vsync = 1'b1;
    tick();
    vsync = 1'b0;
    check("dline_held_in_conv", dline, all_sp);
    wait_done("c0de");

    capture(16'h1234, 8'h00, 8'hFF, 16'h0002, 1'b1);
    wait_done("second");

    // ena low: three frames of vsync must change nothing.
    saved = dline;
    ena = 1'b0;
    for (int fr = 0; fr < 3; fr++) begin
      vsync = 1'b1; tick();
      vsync = 1'b0; repeat (5) tick();
    end
    check("ena0_dline", dline, saved);
    check("ena0_busy", {159'b0, busy}, 160'd0);
    capture(16'hABCD, 8'h12, 8'h34, 16'h0003, 1'b1);
    wait_done("after_ena0");

    // Reset during CONV discards the partial conversion and the counter.
    capture(16'h9876, 8'hEE, 8'h55, 16'h0004, 1'b0);
    repeat (5) tick();
    reset = 1'b1;
    #1;
    check("midreset_dline", dline, all_sp);
    check("midreset_busy", {159'b0, busy}, 160'd0);
    check("midreset_upd", {159'b0, upd}, 160'd0);
    repeat (2) tick();
    reset = 1'b0;
    repeat (20) tick();
    check("after_midreset_dline", dline, all_sp);

    // Conversion already running finishes even if ena drops.
    capture(16'h0F0F, 8'hF0, 8'h0F, 16'h0000, 1'b1);
    ena = 1'b0;
    wait_done("ena_drop");
    ena = 1'b1;

`ifdef DBG_FRAME_CNT_EN
    reset = 1'b1; tick(); reset = 1'b0; tick();
    ignore_upd = 1'b1;
    for (int i = 0; i < 65535; i++) begin
      vsync = 1'b1; tick();
      vsync = 1'b0; tick();
    end
    wait_done("preset");
    repeat (3) tick();
    ignore_upd = 1'b0;
    capture(16'h4242, 8'h42, 8'h42, 16'hFFFF, 1'b1);
    wait_done("wrap_ffff");
    capture(16'h4243, 8'h43, 8'h43, 16'h0000, 1'b1);
    wait_done("wrap_0000");
`endif

    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: %0d lines still pending, required 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dbg_line_fmt.md
DBG_LINE_FMT -- requirements
Module: dbg_line_fmt

Interface
REQ-001 SHALL have port clk, input, 1 bit: system clock (clk_sys domain); all logic is on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port ena, input, 1 bit: capture enable.
REQ-004 SHALL have port vsync, input, 1 bit: video vertical sync, already synchronous to clk.
REQ-005 SHALL have port cpu_addr, input, 16 bits: CPU address to display.
REQ-006 SHALL have port cpu_data, input, 8 bits: CPU data to display.
REQ-007 SHALL have port flags, input, 8 bits: status flags to display.
REQ-008 SHALL have port dline, output, 160 bits: 32 five-bit overlay character codes; slot 31 = [159:155] (leftmost), slot 0 = [4:0].
REQ-009 SHALL have port upd, output, 1 bit: one-cycle pulse when dline changes.
REQ-010 SHALL have port busy, output, 1 bit: high while a conversion is in progress.

Function
REQ-011 SHALL use character codes 0x00-0x0F for hex digits 0-F and 0x10 for space.
REQ-012 SHALL define a capture edge as a clock edge with vsync=1, previous vsync=0, and ena=1.
REQ-013 SHALL, on a capture edge with FSM in IDLE (edge T0), snapshot cpu_addr, cpu_data, flags and frame count, then enter CONV.
REQ-014 SHALL, in CONV, convert one nibble per cycle, MSB first, writing nibble k (k=0..11) to a shadow line at edge T0+1+k.
REQ-015 SHALL use this line layout: slots 31-28 addr; 27 space; 26-25 data; 24 space; 23-22 flags; 21 space; 20-17 frame count; slots 16-0 space.
REQ-016 SHALL enter PUBLISH after nibble 11, copy the whole shadow to dline at edge T0+13 (atomic), assert upd for exactly that cycle, and return to IDLE.
REQ-017 SHALL assert busy in CONV and PUBLISH and deassert it in IDLE.
REQ-018 SHALL keep a 16-bit frame counter that increments by 1 on every capture edge, including edges ignored while busy, and wraps from 0xFFFF to 0x0000.
REQ-019 SHALL snapshot the frame-counter value from before the increment.
REQ-020 SHALL, on a capture edge while busy, perform no new snapshot and leave the running conversion unaffected.
REQ-021 SHALL, when ena=0, perform no capture, no counter change and no dline change; a conversion already in CONV still completes.
REQ-022 SHALL keep input changes after T0 from affecting the line being converted.

Reset
REQ-023 SHALL, on asserted reset and regardless of clk: set dline and shadow to all 0x10, FSM to IDLE, upd=0, busy=0, frame counter=0, and previous-vsync register=0.
REQ-024 SHALL, on reset during CONV, discard the partial shadow; dline reads all 0x10 after release.

Configuration
REQ-025 SHALL, with DBG_FRAME_CNT_EN defined, implement the frame counter and fill slots 20-17 with its value.
REQ-026 SHALL, without DBG_FRAME_CNT_EN, omit the counter, hold slots 20-17 at 0x10, and still take 12 CONV cycles so latency is unchanged.

Structure
REQ-027 SHALL place the character-code constants (hex base, SPACE=0x10), the slot count (32), the code width (5), the nibble count (12) and the FSM state enum (IDLE, CONV, PUBLISH) in a shared package dbg_ovl_pkg.
REQ-028 SHALL implement nibble-to-code mapping as sub-module dbg_hex_char (4-bit in, 5-bit out, combinational).

Verification
REQ-029 SHALL cover: reset release, then read dline -> all 32 slots = 0x10; upd=0; busy=0.
REQ-030 SHALL cover: ena=1, addr=0xC0DE, data=0x5A, flags=0x81, vsync rise at T0 -> at T0+13 slots 31..17 = C,0,D,E,10,5,A,10,8,1,10,0,0,0,0; one-cycle upd pulse.
REQ-031 SHALL cover: second vsync rise at T0+5 -> no restart; result equals the first snapshot; next capture shows frame count 0x0002.
REQ-032 SHALL cover: counter preset to 0xFFFF via 65535 captures, then capture -> slots 20-17 = F,F,F,F; next capture shows 0,0,0,0.
REQ-033 SHALL cover: reset asserted at T0+6 -> dline all 0x10 and busy=0 immediately; no upd.
REQ-034 SHALL cover: ena=0 with vsync toggling 3 frames -> dline, counter and upd unchanged.
